// File: rtl/multiplayer_link.sv
// Full-duplex UART status link between two game boards: broadcasts local status frames
// and tracks the opponent's ready/game-over/multiplayer flags with a link timeout.
module multiplayer_link #(
    parameter int unsigned CLKS_PER_BIT     = 564,
    parameter int unsigned HEARTBEAT_CYCLES = 650000,
    parameter int unsigned TIMEOUT_CYCLES   = 6500000
) (
    input  logic clk,
    input  logic rst,
    input  logic player_ready_in,
    input  logic game_over_in,
    input  logic multiplayer_in,
    input  logic rx,
    output logic tx,
    output logic opponent_ready,
    output logic victory,
    output logic link_up,
    output logic frame_error
);
    localparam int unsigned BitW = $clog2(CLKS_PER_BIT);
    localparam int unsigned HbW  = $clog2(HEARTBEAT_CYCLES);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES);

    localparam logic [BitW-1:0] BitLast  = BitW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] HalfLast = BitW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [HbW-1:0]  HbLast   = HbW'(HEARTBEAT_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      SyncNib  = 4'hA;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [2:0] status;
    assign status = {multiplayer_in, game_over_in, player_ready_in};

    // ---------------- transmitter ----------------
    state_e          tx_state_q, tx_state_d;
    logic [BitW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [HbW-1:0]  hb_cnt_q, hb_cnt_d;
    logic [2:0]      last_sent_q, last_sent_d;
    logic            pending_q, pending_d;
    logic            tx_q, tx_d;
    logic            tx_load;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_shift_d  = tx_shift_q;
        last_sent_d = last_sent_q;
        tx_load     = 1'b0;
        hb_cnt_d    = (hb_cnt_q == HbLast) ? hb_cnt_q : hb_cnt_q + HbW'(1);
        pending_d   = pending_q | (status != last_sent_q) | (hb_cnt_d == HbLast);

        unique case (tx_state_q)
            StIdle:  tx_load = pending_q;
            StStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = StData;
                end else begin
                    tx_cnt_d = tx_cnt_q + BitW'(1);
                end
            end
            StData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == 3'd7) tx_state_d = StStop;
                    else                  tx_idx_d   = tx_idx_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + BitW'(1);
                end
            end
            StStop: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    // Pending work chains straight into the next start bit.
                    if (pending_q) tx_load    = 1'b1;
                    else           tx_state_d = StIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + BitW'(1);
                end
            end
            default: tx_state_d = StIdle;
        endcase

        if (tx_load) begin
            tx_state_d  = StStart;
            tx_cnt_d    = '0;
            tx_shift_d  = {SyncNib, 1'b0, status};
            last_sent_d = status;
            pending_d   = 1'b0;
            hb_cnt_d    = '0;
        end

        unique case (tx_state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q  <= StIdle;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_shift_q  <= '0;
            hb_cnt_q    <= '0;
            last_sent_q <= '0;
            pending_q   <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_shift_q  <= tx_shift_d;
            hb_cnt_q    <= hb_cnt_d;
            last_sent_q <= last_sent_d;
            pending_q   <= pending_d;
            tx_q        <= tx_d;
        end
    end

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    state_e          rx_state_q, rx_state_d;
    logic [BitW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            rx_mp_q, rx_mp_d, rx_go_q, rx_go_d, rx_ready_q, rx_ready_d;
    logic            link_q, link_d;
    logic            ferr_q, opp_q, vic_q;
    logic            rx_valid, rx_bad;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        rx_bad     = 1'b0;

        unique case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = '0;
                end
            end
            StStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    // A start bit that is high again at its centre was a glitch.
                    rx_state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + BitW'(1);
                end
            end
            StData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) rx_state_d = StStop;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + BitW'(1);
                end
            end
            StStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = StIdle;
                    if (rx_sync_q && rx_shift_q[7:4] == SyncNib && !rx_shift_q[3]) rx_valid = 1'b1;
                    else                                                           rx_bad   = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + BitW'(1);
                end
            end
            default: rx_state_d = StIdle;
        endcase

        to_cnt_d   = (to_cnt_q == ToLast) ? to_cnt_q : to_cnt_q + ToW'(1);
        link_d     = link_q;
        rx_mp_d    = rx_mp_q;
        rx_go_d    = rx_go_q;
        rx_ready_d = rx_ready_q;
        if (rx_valid) begin
            link_d     = 1'b1;
            to_cnt_d   = '0;
            rx_mp_d    = rx_shift_q[2];
            rx_go_d    = rx_shift_q[1];
            rx_ready_d = rx_shift_q[0];
        end else if (to_cnt_q == ToLast) begin
            link_d     = 1'b0;
            rx_mp_d    = 1'b0;
            rx_go_d    = 1'b0;
            rx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            to_cnt_q   <= '0;
            rx_mp_q    <= 1'b0;
            rx_go_q    <= 1'b0;
            rx_ready_q <= 1'b0;
            link_q     <= 1'b0;
            ferr_q     <= 1'b0;
            opp_q      <= 1'b0;
            vic_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            to_cnt_q   <= to_cnt_d;
            rx_mp_q    <= rx_mp_d;
            rx_go_q    <= rx_go_d;
            rx_ready_q <= rx_ready_d;
            link_q     <= link_d;
            ferr_q     <= rx_bad;
            opp_q      <= link_q & rx_ready_q;
            vic_q      <= link_q & multiplayer_in & rx_mp_q & rx_go_q & ~game_over_in;
        end
    end

    assign tx             = tx_q;
    assign opponent_ready = opp_q;
    assign victory        = vic_q;
    assign link_up        = link_q;
    assign frame_error    = ferr_q;

endmodule

// File: tb/tb_multiplayer_link.sv
// Randomised bench for multiplayer_link: a behavioural UART monitor decodes tx frames and a
// frame-level model of the remote side predicts link_up/opponent_ready/victory/frame_error.
module tb_multiplayer_link;
    localparam int CPB  = 4;
    localparam int HB   = 200;
    localparam int TO   = 500;
    localparam int Half = CPB / 2;
    localparam int Span = Half + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic player_ready_in = 1'b0, game_over_in = 1'b0, multiplayer_in = 1'b0;
    logic rx, tx, opponent_ready, victory, link_up, frame_error;
    logic loopback = 1'b0;
    logic rx_drv = 1'b1;

    assign rx = loopback ? tx : rx_drv;

    multiplayer_link #(
        .CLKS_PER_BIT    (CPB),
        .HEARTBEAT_CYCLES(HB),
        .TIMEOUT_CYCLES  (TO)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .player_ready_in(player_ready_in),
        .game_over_in   (game_over_in),
        .multiplayer_in (multiplayer_in),
        .rx             (rx),
        .tx             (tx),
        .opponent_ready (opponent_ready),
        .victory        (victory),
        .link_up        (link_up),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int ferr_cnt = 0;
    int link_drops = 0;
    logic watch_link = 1'b0;
    always @(negedge clk) if (frame_error) ferr_cnt <= ferr_cnt + 1;
    always @(negedge clk) if (watch_link && !link_up) link_drops <= link_drops + 1;

    // Remote-side model
    logic rm_link, rm_mp, rm_go, rm_ready;
    logic [2:0] cur;

    int         mon_sc[$];
    logic [7:0] mon_b[$];
    logic       mon_ok[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] encode(input logic [2:0] s);
        return {4'hA, 1'b0, s};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_status(input logic [2:0] s);
        {multiplayer_in, game_over_in, player_ready_in} = s;
        cur = s;
    endtask

    task automatic flush();
        mon_sc.delete();
        mon_b.delete();
        mon_ok.delete();
    endtask

    task automatic wait_frame(input string tag, input int budget, output int sc,
                              output logic [7:0] b, output logic ok);
        int n;
        n = 0;
        while (mon_sc.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_seen"}, 32'(mon_sc.size() != 0), 1);
        if (mon_sc.size() != 0) begin
            sc = mon_sc.pop_front();
            b  = mon_b.pop_front();
            ok = mon_ok.pop_front();
        end else begin
            sc = -1;
            b  = 8'h00;
            ok = 1'b0;
        end
    endtask

    task automatic wait_sig(input bit use_opp, input logic level, input int budget, output int at);
        int n;
        n = 0;
        while (((use_opp ? opponent_ready : link_up) !== level) && n < budget) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            step(CPB);
        end
        rx_drv = stop;
        step(CPB);
        rx_drv = 1'b1;
    endtask

    // Behavioural UART receiver on tx; a reset mid-frame discards the capture.
    initial begin : tx_monitor
        logic prev, ab, ok;
        logic [7:0] b;
        int k, sc, bi;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && prev && !tx) begin
                sc = cyc;
                ab = 1'b0;
                ok = 1'b0;
                b  = 8'h00;
                k  = 0;
                while (k < Span) begin
                    @(negedge clk);
                    k++;
                    if (!rst) begin
                        ab = 1'b1;
                        break;
                    end
                    if (k > Half && ((k - Half) % CPB) == 0) begin
                        bi = (k - Half) / CPB;
                        if (bi <= 8) b[bi-1] = tx;
                        else         ok = tx;
                    end
                end
                if (!ab) begin
                    mon_sc.push_back(sc);
                    mon_b.push_back(b);
                    mon_ok.push_back(ok);
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : main
        int sc, c0, m, rl, ro, fl, fo, prev_sc, bad_run, kind, f0;
        logic [7:0] b;
        logic ok, valid, stop, opp_b, link_b;
        logic [2:0] s, s1, s2;

        cur = 3'b000;
        // Reset behaviour
        step(3);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_opp", opponent_ready, 0);
        check_eq("rst_vic", victory, 0);
        check_eq("rst_link", link_up, 0);
        check_eq("rst_ferr", frame_error, 0);
        rst = 1'b1;
        loopback = 1'b1;
        step(10);

        // Ready rises: one 0xA1 frame, remote side sees it through the loop
        set_status(3'b001);
        c0 = cyc;
        wait_sig(1'b1, 1'b1, 50, m);
        check_eq("p1_opp_ready", opponent_ready, 1);
        check_eq("p1_link_up", link_up, 1);
        wait_frame("p1", 10, sc, b, ok);
        check_eq("p1_byte", b, 8'hA1);
        check_eq("p1_stop", ok, 1);
        check_eq("p1_latency", sc - c0, 2);

        // Heartbeat every HB cycles with steady inputs
        prev_sc = sc;
        watch_link = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_frame("hb", HB + 60, sc, b, ok);
            check_eq("hb_byte", b, 8'hA1);
            check_eq("hb_period", sc - prev_sc, HB);
            prev_sc = sc;
        end
        watch_link = 1'b0;
        step(1);
        check_eq("hb_link_held", link_drops, 0);

        // Random status changes over the loop
        for (int i = 0; i < 6; i++) begin
            step(3);
            s = cur ^ 3'($urandom_range(1, 7));
            set_status(s);
            c0 = cyc;
            wait_frame("txr", 60, sc, b, ok);
            check_eq("txr_byte", b, encode(s));
            check_eq("txr_latency", sc - c0, 2);
            step(8);
            check_eq("txr_opp", opponent_ready, s[0]);
            check_eq("txr_link", link_up, 1);
            check_eq("txr_vic", victory, 0);
        end

        // Drive rx directly from here on
        loopback = 1'b0;
        rm_link  = 1'b1;
        rm_mp    = cur[2];
        rm_go    = cur[1];
        rm_ready = cur[0];

        opp_b  = opponent_ready;
        link_b = link_up;
        f0 = ferr_cnt;
        send_rx(8'h51, 1'b1);
        step(8);
        check_eq("bad51_ferr", ferr_cnt - f0, 1);
        check_eq("bad51_opp", opponent_ready, opp_b);
        check_eq("bad51_link", link_up, link_b);

        f0 = ferr_cnt;
        rx_drv = 1'b0;
        step(1);
        rx_drv = 1'b1;
        step(10);
        check_eq("glitch_ferr", ferr_cnt - f0, 0);
        check_eq("glitch_link", link_up, link_b);

        bad_run = 0;
        for (int i = 0; i < 16; i++) begin
            set_status(3'($urandom_range(0, 7)));
            valid = ($urandom_range(0, 1) == 1) || (bad_run == 3);
            stop  = 1'b1;
            if (valid) begin
                b = encode(3'($urandom_range(0, 7)));
                bad_run = 0;
            end else begin
                kind = $urandom_range(0, 2);
                b = 8'($urandom);
                if (kind == 0) begin
                    if (b[7:4] == 4'hA) b[7:4] = 4'h5;
                end else if (kind == 1) begin
                    b[7:3] = 5'b10101;
                end else begin
                    b = encode(b[2:0]);
                    stop = 1'b0;
                end
                bad_run++;
            end
            f0 = ferr_cnt;
            send_rx(b, stop);
            step(8);
            if (valid) begin
                rm_link  = 1'b1;
                rm_mp    = b[2];
                rm_go    = b[1];
                rm_ready = b[0];
            end
            check_eq("rxr_ferr", ferr_cnt - f0, valid ? 0 : 1);
            check_eq("rxr_link", link_up, rm_link);
            check_eq("rxr_opp", opponent_ready, rm_link & rm_ready);
            check_eq("rxr_vic", victory,
                     rm_link & multiplayer_in & rm_mp & rm_go & ~game_over_in);
        end

        // Victory then local game over
        set_status(3'b100);
        send_rx(8'hA6, 1'b1);
        step(8);
        check_eq("vic_set", victory, 1);
        check_eq("vic_opp", opponent_ready, 0);
        game_over_in = 1'b1;
        cur = 3'b110;
        #1;
        check_eq("vic_hold", victory, 1);
        step(1);
        check_eq("vic_clear", victory, 0);

        // Timeout: expire, then one valid frame and measure the hold time
        wait_sig(1'b0, 1'b0, TO + 100, m);
        check_eq("to_expire", link_up, 0);
        step(2);
        check_eq("to_opp", opponent_ready, 0);
        check_eq("to_vic", victory, 0);
        send_rx(8'hA1, 1'b1);
        wait_sig(1'b0, 1'b1, 60, rl);
        check_eq("to_link_rise", link_up, 1);
        wait_sig(1'b1, 1'b1, 5, ro);
        check_eq("to_opp_rise", opponent_ready, 1);
        wait_sig(1'b0, 1'b0, TO + 50, fl);
        check_eq("to_link_fall", link_up, 0);
        check_eq("to_link_span", fl - rl, TO);
        wait_sig(1'b1, 1'b0, 5, fo);
        check_eq("to_opp_span", fo - ro, TO);

        // Reset in the middle of a TX frame
        flush();
        wait_frame("p6_idle", HB + 60, sc, b, ok);
        step(3);
        loopback = 1'b1;
        s1 = (cur == 3'b001) ? 3'b011 : 3'b001;
        s2 = 3'b101;
        set_status(s1);
        wait_frame("p6_s1", 60, sc, b, ok);
        check_eq("p6_s1_byte", b, encode(s1));
        step(8);
        check_eq("p6_pre_link", link_up, 1);
        check_eq("p6_pre_opp", opponent_ready, 1);
        flush();
        set_status(s2);
        c0 = cyc;
        step(19);
        check_eq("p6_bit3_low", tx, 0);
        rst = 1'b0;
        #1;
        check_eq("p6_rst_tx", tx, 1);
        check_eq("p6_rst_opp", opponent_ready, 0);
        check_eq("p6_rst_link", link_up, 0);
        check_eq("p6_rst_vic", victory, 0);
        check_eq("p6_rst_ferr", frame_error, 0);
        step(3);
        rst = 1'b1;
        m = cyc;
        wait_frame("p6_resend", 60, sc, b, ok);
        check_eq("p6_resend_latency", sc - m, 2);
        check_eq("p6_resend_byte", b, encode(s2));
        check_eq("p6_resend_stop", ok, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multiplayer_link.md
MULTIPLAYER_LINK -- requirements
Module: multiplayer_link

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 564, giving clock cycles per serial bit (65 MHz / 115200 baud).
REQ-002 The block SHALL have parameter HEARTBEAT_CYCLES, default 650000, giving the maximum idle gap between transmitted frames.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 6500000, giving the silence after the last valid received frame that drops the link.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port player_ready_in, input, 1 bit: local player ready status.
REQ-007 The block SHALL have port game_over_in, input, 1 bit: local game over status.
REQ-008 The block SHALL have port multiplayer_in, input, 1 bit: local multiplayer mode selected.
REQ-009 The block SHALL have port rx, input, 1 bit: serial line from the opponent board; asynchronous, idles high.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line to the opponent board; idles high.
REQ-011 The block SHALL have port opponent_ready, output, 1 bit: the remote player is ready.
REQ-012 The block SHALL have port victory, output, 1 bit: the remote player lost while the local player is still alive.
REQ-013 The block SHALL have port link_up, output, 1 bit: a valid frame arrived within TIMEOUT_CYCLES.
REQ-014 The block SHALL have port frame_error, output, 1 bit: one-cycle pulse on each rejected frame.

Function
REQ-015 Frame format SHALL be: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts CLKS_PER_BIT cycles.
REQ-016 The data byte SHALL be laid out as follows: [7:4] = 4'hA sync, [3] = 0, [2] = multiplayer, [1] = game_over, [0] = player_ready.
REQ-017 The TX FSM SHALL use states IDLE, START, DATA (8 bits), STOP; tx SHALL be 1 in IDLE and STOP, 0 in START, and the data bit in DATA.
REQ-018 A pending flag SHALL set when the {multiplayer, game_over, player_ready} inputs differ from the last sent value, or when the heartbeat counter reaches HEARTBEAT_CYCLES-1.
REQ-019 On a cycle with TX in IDLE and pending = 1, the block SHALL snapshot the status, clear pending and the heartbeat counter, and enter START on the next cycle.
REQ-020 An input change during a frame SHALL leave the frame in progress unchanged; it SHALL set pending, and the value present at the next frame start SHALL be sent (back-to-back, no gap cycle required).
REQ-021 rx SHALL pass through a 2-flop synchronizer; the RX FSM SHALL use states IDLE, START, DATA, STOP.
REQ-022 A synchronized rx 1->0 edge in IDLE SHALL enter START; at CLKS_PER_BIT/2 the block SHALL resample, and a high level there SHALL return to IDLE silently as a glitch (no frame_error).
REQ-023 Each data bit and the stop bit SHALL be sampled at bit centre, i.e. every CLKS_PER_BIT cycles after the start-bit centre.
REQ-024 A frame SHALL be valid iff stop = 1, byte[7:4] = 4'hA and byte[3] = 0.
REQ-025 On a valid frame, the block SHALL update the remote registers {rx_mp, rx_go, rx_ready} in the stop-sample cycle; link_up SHALL be 1 and the timeout counter 0 on the following cycle.
REQ-026 An invalid frame SHALL pulse frame_error for exactly 1 cycle and leave the remote registers unchanged.
REQ-027 The timeout counter SHALL increment every cycle without a valid frame and saturate; on reaching TIMEOUT_CYCLES-1 it SHALL clear link_up and the remote registers.
REQ-028 A valid frame and a timeout expiry in the same cycle SHALL resolve in favour of the valid frame.
REQ-029 opponent_ready SHALL be registered as link_up & rx_ready.
REQ-030 victory SHALL be registered as link_up & multiplayer_in & rx_mp & rx_go & ~game_over_in, so it follows input changes with 1-cycle latency.
REQ-031 TX and RX SHALL be fully independent, and full-duplex operation SHALL be supported.

Reset
REQ-032 While rst = 0, the block SHALL immediately force tx = 1 and opponent_ready, victory, link_up and frame_error to 0.
REQ-033 While rst = 0, both FSMs SHALL be in IDLE and all counters, pending, the remote registers and the last-sent register SHALL be 0.
REQ-034 A frame interrupted by reset SHALL be abandoned; after reset release the pending logic SHALL resend any nonzero status.

Verification (CLKS_PER_BIT=4, HEARTBEAT_CYCLES=200, TIMEOUT_CYCLES=500, tx looped to rx)
REQ-035 player_ready_in 0->1 -> tx sends byte 0xA1 (40 cycles); opponent_ready=1 and link_up=1 within 50 cycles of the change.
REQ-036 Inputs held constant -> an identical 0xA1 frame starts every 200 cycles; link_up never drops.
REQ-037 Drive rx with byte 0x51 -> frame_error is high for exactly 1 cycle; opponent_ready/link_up are unchanged.
REQ-038 Hold rx=1 after the last valid frame -> link_up and opponent_ready fall exactly 500 cycles later.
REQ-039 multiplayer_in=1, game_over_in=0, receive 0xA6 -> victory=1; then set game_over_in=1 -> victory=0 one cycle later.
REQ-040 Assert rst=0 during data bit 3 of a TX frame -> tx=1 and all outputs 0 in the same cycle; no partial frame resumes after release.
